// File: rtl/ttl_ecl_xmit.sv
// rtl/ttl_ecl_xmit.sv - TTL-to-ECL transmit buffer with a four-phase ECL handshake
// Odd-parity outputs P/P_ are added when TTL_ECL_XMIT_PARITY_EN is defined.
module ttl_ecl_xmit #(
    parameter int DEPTH = 4
) (
    input  logic       CLK,
    input  logic       MR_,
    input  logic [8:0] D,
    input  logic       LD,
    output logic       FULL,
    output logic       OVF,
    input  logic       OEECL_,
    output logic [8:0] Q,
    output logic [8:0] Q_,
    output logic       STB,
`ifdef TTL_ECL_XMIT_PARITY_EN
    output logic       P,
    output logic       P_,
`endif
    input  logic       ACK
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0]   CNT_FULL = (PW+1)'(DEPTH);
    localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH-1);

    typedef enum logic [1:0] {IDLE, PRESENT, RELEASE} state_e;

    state_e        state_q, state_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW:0]   cnt_q, cnt_d;
    logic          full_q, full_d;
    logic          ovf_q, ovf_d;
    logic          run_q, run_d;
    logic          ack_meta_q, ack_meta_d;
    logic          acks_q, acks_d;
    logic [8:0]    out_q, out_d;
    logic [8:0]    mem_q [DEPTH];
    logic          wr_en;
    logic          pop;

    always_comb begin
        run_d      = 1'b1;
        ack_meta_d = ACK;
        acks_d     = ack_meta_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        cnt_d      = cnt_q;
        state_d    = state_q;
        out_d      = out_q;

        // Fullness is judged before the edge, so a same-edge pop never makes room.
        wr_en = LD && run_q && (cnt_q != CNT_FULL);
        pop   = (state_q == IDLE) && (cnt_q != '0);
        ovf_d = ovf_q | (LD && run_q && (cnt_q == CNT_FULL));

        if (wr_en) begin
            wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PW'(1);
        end
        case ({wr_en, pop})
            2'b10:   cnt_d = cnt_q + (PW+1)'(1);
            2'b01:   cnt_d = cnt_q - (PW+1)'(1);
            default: cnt_d = cnt_q;
        endcase
        full_d = (cnt_d == CNT_FULL);

        case (state_q)
            IDLE: begin
                if (pop) begin
                    out_d   = mem_q[rd_ptr_q];
                    state_d = PRESENT;
                end
            end
            PRESENT: if (acks_q)  state_d = RELEASE;
            RELEASE: if (!acks_q) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge MR_) begin
        if (!MR_) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            full_q     <= 1'b0;
            ovf_q      <= 1'b0;
            run_q      <= 1'b0;
            ack_meta_q <= 1'b0;
            acks_q     <= 1'b0;
            out_q      <= '0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
            full_q     <= full_d;
            ovf_q      <= ovf_d;
            run_q      <= run_d;
            ack_meta_q <= ack_meta_d;
            acks_q     <= acks_d;
            out_q      <= out_d;
        end
    end

    // Storage needs no reset: pointers and occupancy define what is valid.
    always_ff @(posedge CLK) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= D;
        end
    end

    assign FULL = full_q;
    assign OVF  = ovf_q;
    assign Q    = OEECL_ ? 9'h000 : out_q;
    assign Q_   = OEECL_ ? 9'h000 : ~out_q;
    assign STB  = !OEECL_ && (state_q == PRESENT);

`ifdef TTL_ECL_XMIT_PARITY_EN
    logic par_q, par_d;

    // out_d only changes on a pop, so parity is captured alongside the word.
    always_comb par_d = ~(^out_d);

    always_ff @(posedge CLK or negedge MR_) begin
        if (!MR_) begin
            par_q <= 1'b1;
        end else begin
            par_q <= par_d;
        end
    end

    assign P  = !OEECL_ && par_q;
    assign P_ = !OEECL_ && !par_q;
`endif
endmodule

// File: tb/tb_ttl_ecl_xmit.sv
// tb/tb_ttl_ecl_xmit.sv - self-checking bench for ttl_ecl_xmit (DEPTH=4)
module tb_ttl_ecl_xmit;
    localparam int DEPTH = 4;

    logic       CLK = 1'b0;
    logic       MR_, LD, OEECL_, ACK;
    logic [8:0] D;
    logic       FULL, OVF, STB;
    logic [8:0] Q, Q_;
`ifdef TTL_ECL_XMIT_PARITY_EN
    logic       P, P_;
`endif

    ttl_ecl_xmit #(.DEPTH(DEPTH)) dut (
        .CLK(CLK), .MR_(MR_), .D(D), .LD(LD), .FULL(FULL), .OVF(OVF),
        .OEECL_(OEECL_), .Q(Q), .Q_(Q_), .STB(STB),
`ifdef TTL_ECL_XMIT_PARITY_EN
        .P(P), .P_(P_),
`endif
        .ACK(ACK)
    );

    always #5 CLK = ~CLK;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: a queue of pending words, the word on display and the handshake phase.
    logic [8:0] m_buf[$];
    logic [8:0] m_out;
    int         m_phase;
    bit         m_ovf, m_full, m_run, m_a1, m_a2;

    task automatic model_reset();
        m_buf.delete();
        m_out = 9'h000; m_phase = 0;
        m_ovf = 1'b0; m_full = 1'b0; m_run = 1'b0; m_a1 = 1'b0; m_a2 = 1'b0;
    endtask

    task automatic model_edge();
        bit full_pre;
        bit ack_s;
        if (!MR_) begin
            model_reset();
            return;
        end
        full_pre = (m_buf.size() == DEPTH);
        ack_s    = m_a2;
        if (m_phase == 0 && m_buf.size() > 0) begin
            m_out   = m_buf.pop_front();
            m_phase = 1;
        end else if (m_phase == 1 && ack_s) begin
            m_phase = 2;
        end else if (m_phase == 2 && !ack_s) begin
            m_phase = 0;
        end
        if (LD && m_run) begin
            if (full_pre) m_ovf = 1'b1;
            else          m_buf.push_back(D);
        end
        m_full = (m_buf.size() == DEPTH);
        m_run  = 1'b1;
        m_a2   = m_a1;
        m_a1   = ACK;
    endtask

    task automatic chk(input string name, input logic [8:0] act, input logic [8:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %03h expected %03h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_model();
        chk("m_q",    Q,         OEECL_ ? 9'h000 : m_out);
        chk("m_qn",   Q_,        OEECL_ ? 9'h000 : ~m_out);
        chk("m_stb",  9'(STB),   9'(!OEECL_ && m_phase == 1));
        chk("m_full", 9'(FULL),  9'(m_full));
        chk("m_ovf",  9'(OVF),   9'(m_ovf));
`ifdef TTL_ECL_XMIT_PARITY_EN
        chk("m_p",    9'(P),     9'(!OEECL_ && !(^m_out)));
        chk("m_pn",   9'(P_),    9'(!OEECL_ && (^m_out)));
`endif
    endtask

    task automatic step();
        @(posedge CLK);
        model_edge();
        #1;
        chk_model();
    endtask

    task automatic do_reset();
        MR_ = 1'b0;
        #1;
        model_reset();
        chk_model();
        step();
        step();
        MR_ = 1'b1;
    endtask

    task automatic handshake(input logic [8:0] exp_next, input bit expect_next);
        int n;
        ACK = 1'b1;
        n = 0;
        do begin step(); n++; end while (STB && n < 8);
        chk("ack_to_stb_fall_edges", 9'(n), 9'd3);
        ACK = 1'b0;
        n = 0;
        do begin step(); n++; end while (!STB && n < 8);
        if (expect_next) begin
            chk("release_to_next_edges", 9'(n), 9'd4);
            chk("next_word", Q, exp_next);
        end else begin
            chk("no_more_words_stb", 9'(STB), 9'd0);
        end
    endtask

    typedef struct packed {
        logic       ld;
        logic [8:0] d;
        logic       ack;
        logic       oen;
        logic [8:0] q;
        logic       stb;
        logic       full;
        logic       ovf;
    } vec_t;

    vec_t tbl[$];

    initial begin
        //            ld    d       ack   oen   q       stb   full  ovf
        tbl.push_back({1'b1, 9'h077, 1'b0, 1'b0, 9'h000, 1'b0, 1'b0, 1'b0});
        tbl.push_back({1'b1, 9'h001, 1'b0, 1'b0, 9'h000, 1'b0, 1'b0, 1'b0});
        tbl.push_back({1'b1, 9'h002, 1'b0, 1'b0, 9'h001, 1'b1, 1'b0, 1'b0});
        tbl.push_back({1'b1, 9'h003, 1'b0, 1'b0, 9'h001, 1'b1, 1'b0, 1'b0});
        tbl.push_back({1'b1, 9'h004, 1'b0, 1'b0, 9'h001, 1'b1, 1'b0, 1'b0});
        tbl.push_back({1'b1, 9'h005, 1'b0, 1'b0, 9'h001, 1'b1, 1'b1, 1'b0});
        tbl.push_back({1'b1, 9'h006, 1'b0, 1'b0, 9'h001, 1'b1, 1'b1, 1'b1});
        tbl.push_back({1'b0, 9'h000, 1'b0, 1'b0, 9'h001, 1'b1, 1'b1, 1'b1});
        tbl.push_back({1'b0, 9'h000, 1'b1, 1'b0, 9'h001, 1'b1, 1'b1, 1'b1});
        tbl.push_back({1'b0, 9'h000, 1'b1, 1'b0, 9'h001, 1'b1, 1'b1, 1'b1});
        tbl.push_back({1'b0, 9'h000, 1'b1, 1'b0, 9'h001, 1'b0, 1'b1, 1'b1});
        tbl.push_back({1'b0, 9'h000, 1'b0, 1'b0, 9'h001, 1'b0, 1'b1, 1'b1});
        tbl.push_back({1'b0, 9'h000, 1'b0, 1'b0, 9'h001, 1'b0, 1'b1, 1'b1});
        tbl.push_back({1'b0, 9'h000, 1'b0, 1'b0, 9'h001, 1'b0, 1'b1, 1'b1});
        tbl.push_back({1'b0, 9'h000, 1'b0, 1'b0, 9'h002, 1'b1, 1'b0, 1'b1});
        tbl.push_back({1'b0, 9'h000, 1'b0, 1'b1, 9'h000, 1'b0, 1'b0, 1'b1});
        tbl.push_back({1'b0, 9'h000, 1'b0, 1'b0, 9'h002, 1'b1, 1'b0, 1'b1});

        LD = 1'b0; D = 9'h000; ACK = 1'b0; OEECL_ = 1'b0;
        do_reset();
        chk("reset_qn_ones", Q_, 9'h1FF);

        foreach (tbl[i]) begin
            LD = tbl[i].ld; D = tbl[i].d; ACK = tbl[i].ack; OEECL_ = tbl[i].oen;
            step();
            chk($sformatf("tbl%0d_q", i),    Q,        tbl[i].q);
            chk($sformatf("tbl%0d_qn", i),   Q_,       tbl[i].oen ? 9'h000 : ~tbl[i].q);
            chk($sformatf("tbl%0d_stb", i),  9'(STB),  9'(tbl[i].stb));
            chk($sformatf("tbl%0d_full", i), 9'(FULL), 9'(tbl[i].full));
            chk($sformatf("tbl%0d_ovf", i),  9'(OVF),  9'(tbl[i].ovf));
        end
        LD = 1'b0; ACK = 1'b0; OEECL_ = 1'b0;

        handshake(9'h003, 1'b1);
        handshake(9'h004, 1'b1);
        handshake(9'h005, 1'b1);
        handshake(9'h000, 1'b0);

        // Reset in PRESENT with three words still queued.
        for (int i = 0; i < 4; i++) begin
            LD = 1'b1; D = 9'h100 + 9'(i);
            step();
        end
        LD = 1'b0;
        chk("pre_reset_q", Q, 9'h100);
        chk("pre_reset_stb", 9'(STB), 9'd1);
        do_reset();
        chk("mid_hs_reset_q", Q, 9'h000);
        chk("mid_hs_reset_stb", 9'(STB), 9'd0);
        for (int i = 0; i < 6; i++) step();
        chk("no_stale_stb", 9'(STB), 9'd0);
        chk("no_stale_ovf", 9'(OVF), 9'd0);

        // First edge after release ignores LD, the second accepts it.
        do_reset();
        LD = 1'b1; D = 9'h0AA; step();
        LD = 1'b1; D = 9'h0BB; step();
        LD = 1'b0; step();
        chk("first_accepted_word", Q, 9'h0BB);
        handshake(9'h000, 1'b0);

        for (int ph = 0; ph < 2; ph++) begin
            for (int i = 0; i < 300; i++) begin
                LD = ($urandom_range(3) < ((ph == 0) ? 3 : 1));
                D = 9'($urandom);
                OEECL_ = ($urandom_range(15) == 0);
                if (!ACK && STB && $urandom_range(2) == 0) ACK = 1'b1;
                else if (ACK && !STB && $urandom_range(2) == 0) ACK = 1'b0;
                step();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
